// File: rtl/fg_period_scheduler_if.sv
// -----------------------------------------------------------------------------
// fg_period_scheduler_if
//
// Configuration channel into the function-generator period scheduler.
//
// Handshake: the producer (master) raises cfg_valid_i with a complete
// parameter set; a transfer happens on every rising clock edge where
// cfg_valid_i && cfg_ready_o. While cfg_valid_i is high and the transfer has
// not happened yet, the producer holds all cfg_* fields stable. cfg_ready_o
// may depend on scheduler state but never on cfg_valid_i.
//
// Signals (directions named from the scheduler's point of view):
//   cfg_valid_i      config offer
//   cfg_ready_o      config slot free
//   cfg_period_i     last CR value of a period (period = value+1 ticks)
//   cfg_on_i         CR value at which the fall begins
//   cfg_k_rise_i     rise slope
//   cfg_k_fall_i     fall slope
//   cfg_amplitude_i  amplitude
//   cfg_prescale_i   enable divider, one tick every prescale+1 cycles
//   cfg_burst_i      periods per run, 0 = continuous
// -----------------------------------------------------------------------------
interface fg_period_scheduler_if #(
    parameter int COUNTER_BITWIDTH   = 32,
    parameter int WAVEFORM_BITWIDTH  = 16,
    parameter int PRESCALER_BITWIDTH = 16,
    parameter int BURST_BITWIDTH     = 8
);
    logic                          cfg_valid_i;
    logic                          cfg_ready_o;
    logic [COUNTER_BITWIDTH-1:0]   cfg_period_i;
    logic [COUNTER_BITWIDTH-1:0]   cfg_on_i;
    logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_rise_i;
    logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_fall_i;
    logic [WAVEFORM_BITWIDTH-1:0]  cfg_amplitude_i;
    logic [PRESCALER_BITWIDTH-1:0] cfg_prescale_i;
    logic [BURST_BITWIDTH-1:0]     cfg_burst_i;

    modport master (
        output cfg_valid_i, cfg_period_i, cfg_on_i, cfg_k_rise_i, cfg_k_fall_i,
               cfg_amplitude_i, cfg_prescale_i, cfg_burst_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i, cfg_period_i, cfg_on_i, cfg_k_rise_i, cfg_k_fall_i,
               cfg_amplitude_i, cfg_prescale_i, cfg_burst_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/fg_period_scheduler.sv
// -----------------------------------------------------------------------------
// fg_period_scheduler
//
// Sequencing controller for the function-generator waveform datapath. Owns
// the prescaler that generates the datapath clock enable, runs the period
// counter register (CR) and holds the active waveform configuration. New
// configurations are double-buffered while running and swapped in only at a
// period wrap, so the datapath never sees a torn parameter set. Supports
// start, stop-at-end-of-period and finite bursts.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, stop_i       run control (level, sampled every cycle)
//   cfg                   configuration channel (slave side)
//   clk_en_o              datapath clock enable (one tick per prescale+1 cycles)
//   cr_o                  counter register seen by the datapath
//   counter_o             active period (last CR value)
//   on_counter_o          active ON count
//   k_rise_o, k_fall_o    active slopes
//   amplitude_o           active amplitude
//   busy_o                scheduler not idle
//   period_done_o         one-cycle pulse after each period wrap
//   burst_done_o          one-cycle pulse after a finite burst completes
//   dbg_state_o           current FSM state (0 IDLE, 1 RUN, 2 STOPPING)
// -----------------------------------------------------------------------------
module fg_period_scheduler #(
    parameter int COUNTER_BITWIDTH   = 32,
    parameter int WAVEFORM_BITWIDTH  = 16,
    parameter int PRESCALER_BITWIDTH = 16,
    parameter int BURST_BITWIDTH     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    fg_period_scheduler_if.slave         cfg,
    output logic                         clk_en_o,
    output logic [COUNTER_BITWIDTH-1:0]  cr_o,
    output logic [COUNTER_BITWIDTH-1:0]  counter_o,
    output logic [COUNTER_BITWIDTH-1:0]  on_counter_o,
    output logic [WAVEFORM_BITWIDTH-1:0] k_rise_o,
    output logic [WAVEFORM_BITWIDTH-1:0] k_fall_o,
    output logic [WAVEFORM_BITWIDTH-1:0] amplitude_o,
    output logic                         busy_o,
    output logic                         period_done_o,
    output logic                         burst_done_o,
    output logic [1:0]                   dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    typedef struct packed {
        logic [COUNTER_BITWIDTH-1:0]   period;
        logic [COUNTER_BITWIDTH-1:0]   on_count;
        logic [WAVEFORM_BITWIDTH-1:0]  k_rise;
        logic [WAVEFORM_BITWIDTH-1:0]  k_fall;
        logic [WAVEFORM_BITWIDTH-1:0]  amplitude;
        logic [PRESCALER_BITWIDTH-1:0] prescale;
        logic [BURST_BITWIDTH-1:0]     burst;
    } cfg_t;

    state_t                        r_state;
    cfg_t                          r_active;
    cfg_t                          r_pending;
    logic                          r_pending_full;
    logic                          r_cfg_loaded;
    logic [PRESCALER_BITWIDTH-1:0] r_pc;
    logic [COUNTER_BITWIDTH-1:0]   r_cr;
    logic [BURST_BITWIDTH-1:0]     r_bc;
    logic                          r_period_done;
    logic                          r_burst_done;

    cfg_t                          w_cfg_in;
    logic                          w_tick;
    logic                          w_cfg_ready;
    logic                          w_accept;
    logic                          w_wrap;
    logic [BURST_BITWIDTH-1:0]     w_bc_next;
    logic                          w_burst_end;

    assign w_cfg_in = '{
        period:    cfg.cfg_period_i,
        on_count:  cfg.cfg_on_i,
        k_rise:    cfg.cfg_k_rise_i,
        k_fall:    cfg.cfg_k_fall_i,
        amplitude: cfg.cfg_amplitude_i,
        prescale:  cfg.cfg_prescale_i,
        burst:     cfg.cfg_burst_i
    };

    assign w_tick      = (r_pc == r_active.prescale);
    // IDLE writes straight to the active set, so the slot is always free there.
    assign w_cfg_ready = (r_state == ST_IDLE) || !r_pending_full;
    assign w_accept    = cfg.cfg_valid_i && w_cfg_ready;
    assign w_wrap      = w_tick && (r_cr == r_active.period);
    assign w_bc_next   = r_bc + 1'b1;
    // Equality (not >=) on purpose: lowering burst below bc+1 mid-run only
    // ends the run once bc wraps around.
    assign w_burst_end = (r_active.burst != '0) && (w_bc_next == r_active.burst);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_active       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_cfg_loaded   <= 1'b0;
            r_pc           <= '0;
            r_cr           <= '0;
            r_bc           <= '0;
            r_period_done  <= 1'b0;
            r_burst_done   <= 1'b0;
        end else begin
            r_period_done <= 1'b0;
            r_burst_done  <= 1'b0;
            r_pc          <= w_tick ? '0 : r_pc + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_active     <= w_cfg_in;
                        r_cfg_loaded <= 1'b1;
                    end
                    if (start_i && !stop_i && (r_cfg_loaded || w_accept)) begin
                        r_state <= ST_RUN;
                        r_cr    <= '0;
                        r_pc    <= '0;
                        r_bc    <= '0;
                    end
                end

                ST_RUN, ST_STOPPING: begin
                    // An accept implies the slot is empty, so it never
                    // coincides with the pending->active swap below; a config
                    // taken on the wrap cycle waits for the next wrap.
                    if (w_accept) begin
                        r_pending      <= w_cfg_in;
                        r_pending_full <= 1'b1;
                    end
                    if ((r_state == ST_RUN) && stop_i) begin
                        r_state <= ST_STOPPING;
                    end
                    if (w_tick) begin
                        if (w_wrap) begin
                            r_cr          <= '0;
                            r_period_done <= 1'b1;
                            r_bc          <= w_bc_next;
                            if (r_pending_full) begin
                                r_active       <= r_pending;
                                r_pending_full <= 1'b0;
                            end
                            if ((r_state == ST_STOPPING) || w_burst_end) begin
                                r_state <= ST_IDLE;
                            end
                            r_burst_done <= w_burst_end;
                        end else begin
                            r_cr <= r_cr + 1'b1;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg.cfg_ready_o = w_cfg_ready;
    assign clk_en_o        = w_tick;
    // While idle the datapath is parked at the end of its period.
    assign cr_o            = (r_state == ST_IDLE) ? r_active.period : r_cr;
    assign counter_o       = r_active.period;
    assign on_counter_o    = r_active.on_count;
    assign k_rise_o        = r_active.k_rise;
    assign k_fall_o        = r_active.k_fall;
    assign amplitude_o     = r_active.amplitude;
    assign busy_o          = (r_state != ST_IDLE);
    assign period_done_o   = r_period_done;
    assign burst_done_o    = r_burst_done;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_fg_period_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fg_period_scheduler
//
// Directed bench for fg_period_scheduler. Per-cycle expectations for each run
// phase are written as tables, pushed to an expected queue when the phase's
// stimulus starts, and popped one per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_fg_period_scheduler;

    localparam int EW = 53; // {ready, period_done, burst_done, busy, clk_en, amplitude[15:0], cr[31:0]}

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        stop_i;
    logic        clk_en_o;
    logic [31:0] cr_o;
    logic [31:0] counter_o;
    logic [31:0] on_counter_o;
    logic [15:0] k_rise_o;
    logic [15:0] k_fall_o;
    logic [15:0] amplitude_o;
    logic        busy_o;
    logic        period_done_o;
    logic        burst_done_o;
    logic [1:0]  dbg_state_o;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];

    fg_period_scheduler_if cfg_bus ();

    fg_period_scheduler dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .cfg           (cfg_bus),
        .clk_en_o      (clk_en_o),
        .cr_o          (cr_o),
        .counter_o     (counter_o),
        .on_counter_o  (on_counter_o),
        .k_rise_o      (k_rise_o),
        .k_fall_o      (k_fall_o),
        .amplitude_o   (amplitude_o),
        .busy_o        (busy_o),
        .period_done_o (period_done_o),
        .burst_done_o  (burst_done_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- expectation tables ----------------
    // Phase A: prescale 0, period 3, live config swaps, then stop on a period-5 run.
    int tab_a_cr[32]   = '{0,1,2,3, 0,1,2,3, 0,1,2,3, 0,1,2,3, 0,1,2,3, 0,1,2,3,
                           0,1,2,3,4,5, 5,5};
    bit tab_a_pd[32]   = '{0,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,0,
                           1,0,0,0,0,0, 1,0};
    bit tab_a_rdy[32]  = '{1,1,1,1, 1,1,1,1, 1,1,1,1, 1,0,0,0, 1,0,0,0, 1,0,0,0,
                           1,1,1,1,1,1, 1,1};
    int tab_a_amp[32]  = '{100,100,100,100, 100,100,100,100, 100,100,100,100,
                           100,100,100,100, 200,200,200,200, 300,300,300,300,
                           300,300,300,300,300,300, 300,300};
    // Phase B: prescale 2, period 1.
    int tab_b_cr[13]   = '{0,0,0,1,1,1,0,0,0,1,1,1,0};
    bit tab_b_ce[13]   = '{0,0,1,0,0,1,0,0,1,0,0,1,0};
    bit tab_b_pd[13]   = '{0,0,0,0,0,0,1,0,0,0,0,0,1};
    // Phase C: burst of 2, period 3, prescale 0.
    int tab_c_cr[10]   = '{0,1,2,3,0,1,2,3,3,3};
    bit tab_c_pd[10]   = '{0,0,0,0,1,0,0,0,1,0};
    bit tab_c_bd[10]   = '{0,0,0,0,0,0,0,0,1,0};
    bit tab_c_busy[10] = '{1,1,1,1,1,1,1,1,0,0};

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] mk(input bit rdy, input bit pd, input bit bd,
                                         input bit busy, input bit ce,
                                         input logic [15:0] amp, input logic [31:0] cr);
        return {rdy, pd, bd, busy, ce, amp, cr};
    endfunction

    function automatic logic [EW-1:0] observed();
        return {cfg_bus.cfg_ready_o, period_done_o, burst_done_o, busy_o, clk_en_o,
                amplitude_o, cr_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scb_check(input string tag, input int idx);
        logic [EW-1:0] e;
        logic [EW-1:0] o;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s[%0d] observed=empty_queue expected=entry", tag, idx);
        end else begin
            e = exp_q.pop_front();
            o = observed();
            assert (o === e) else begin
                failures++;
                $error("FAIL %s[%0d] observed={rdy,pd,bd,busy,ce,amp,cr}=%h expected=%h",
                       tag, idx, o, e);
            end
        end
    endtask

    task automatic drive_cfg(input logic [31:0] period, input logic [31:0] on_cnt,
                             input logic [15:0] kr, input logic [15:0] kf,
                             input logic [15:0] amp, input logic [15:0] presc,
                             input logic [7:0] burst);
        cfg_bus.cfg_valid_i     = 1'b1;
        cfg_bus.cfg_period_i    = period;
        cfg_bus.cfg_on_i        = on_cnt;
        cfg_bus.cfg_k_rise_i    = kr;
        cfg_bus.cfg_k_fall_i    = kf;
        cfg_bus.cfg_amplitude_i = amp;
        cfg_bus.cfg_prescale_i  = presc;
        cfg_bus.cfg_burst_i     = burst;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int waited;
        rst_i   = 1'b1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        cfg_bus.cfg_valid_i = 1'b0;
        drive_cfg(0, 0, 0, 0, 0, 0, 0);
        cfg_bus.cfg_valid_i = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk_i);
        chk("rst_busy",    32'(busy_o), 0);
        chk("rst_cr",      cr_o, 0);
        chk("rst_clk_en",  32'(clk_en_o), 1);
        chk("rst_ready",   32'(cfg_bus.cfg_ready_o), 1);
        chk("rst_amp",     32'(amplitude_o), 0);
        chk("rst_pdone",   32'(period_done_o), 0);
        rst_i = 1'b0;

        // A start with no configuration ever loaded stays idle.
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("start_unloaded_busy", 32'(busy_o), 0);

        // Idle load goes straight to the active registers.
        drive_cfg(3, 2, 5, 6, 100, 0, 0);
        @(negedge clk_i);
        cfg_bus.cfg_valid_i = 1'b0;
        chk("load_counter", counter_o, 3);
        chk("load_on",      on_counter_o, 2);
        chk("load_krise",   32'(k_rise_o), 5);
        chk("load_kfall",   32'(k_fall_o), 6);
        chk("load_amp",     32'(amplitude_o), 100);
        chk("idle_cr_park", cr_o, 3);
        chk("idle_busy",    32'(busy_o), 0);

        // Phase A.
        for (int i = 0; i < 32; i++)
            exp_q.push_back(mk(tab_a_rdy[i], tab_a_pd[i], 1'b0, (i < 30), 1'b1,
                               16'(tab_a_amp[i]), 32'(tab_a_cr[i])));
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            scb_check("run_a", i);
            case (i)
                12: drive_cfg(3, 2, 5, 6, 200, 0, 0);   // accepted mid-period
                13: drive_cfg(3, 2, 5, 6, 300, 0, 0);   // stalled while slot full
                17: cfg_bus.cfg_valid_i = 1'b0;
                20: drive_cfg(5, 4, 5, 6, 300, 0, 0);   // period 5 for the stop test
                21: cfg_bus.cfg_valid_i = 1'b0;
                25: stop_i = 1'b1;                      // CR == 1
                26: begin stop_i = 1'b0; start_i = 1'b1; end // start while stopping
                27: start_i = 1'b0;
                default: ;
            endcase
            @(negedge clk_i);
        end
        chk("a_counter_final", counter_o, 5);
        chk("a_on_final",      on_counter_o, 4);

        // Phase B.
        drive_cfg(1, 1, 0, 0, 7, 2, 0);
        @(negedge clk_i);
        cfg_bus.cfg_valid_i = 1'b0;
        for (int i = 0; i < 13; i++)
            exp_q.push_back(mk(1'b1, tab_b_pd[i], 1'b0, 1'b1, tab_b_ce[i],
                               16'd7, 32'(tab_b_cr[i])));
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 13; i++) begin
            scb_check("run_b", i);
            if (i == 12) stop_i = 1'b1;
            @(negedge clk_i);
        end
        stop_i = 1'b0;
        waited = 0;
        while (busy_o && waited < 40) begin
            @(negedge clk_i);
            waited++;
        end
        chk("b_stop_reaches_idle", 32'(busy_o), 0);

        // Phase C: config offered together with start; the start uses it.
        for (int i = 0; i < 10; i++)
            exp_q.push_back(mk(1'b1, tab_c_pd[i], tab_c_bd[i], tab_c_busy[i], 1'b1,
                               16'd9, 32'(tab_c_cr[i])));
        drive_cfg(3, 0, 0, 0, 9, 0, 2);
        start_i = 1'b1;
        @(negedge clk_i);
        cfg_bus.cfg_valid_i = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            scb_check("run_c", i);
            @(negedge clk_i);
        end

        // Phase D: reset while running with a pending config.
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("d_busy", 32'(busy_o), 1);
        drive_cfg(3, 0, 0, 0, 55, 0, 0);
        @(negedge clk_i);
        cfg_bus.cfg_valid_i = 1'b0;
        chk("d_pending_full_ready", 32'(cfg_bus.cfg_ready_o), 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("d_rst_busy",    32'(busy_o), 0);
        chk("d_rst_cr",      cr_o, 0);
        chk("d_rst_counter", counter_o, 0);
        chk("d_rst_amp",     32'(amplitude_o), 0);
        chk("d_rst_ready",   32'(cfg_bus.cfg_ready_o), 1);
        chk("d_rst_clk_en",  32'(clk_en_o), 1);
        chk("d_rst_pdone",   32'(period_done_o), 0);
        chk("d_rst_bdone",   32'(burst_done_o), 0);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("d_start_unloaded", 32'(busy_o), 0);
        repeat (3) @(negedge clk_i);
        chk("d_still_idle", 32'(busy_o), 0);
        chk("d_queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
